adder_cla_seq: RTL

- Multi-precision add/subtract sequencer built around one shared N-bit adder_cla instance.
- Processes N*M-bit operands as M slices of N bits, one slice per clock, LSB slice first. The carry is registered between slices.
- Upstream and downstream use valid/ready handshakes. The block lets narrow CLA hardware serve wide datapath operations.

---
 rtl/adder_cla_seq.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/adder_cla_seq.sv
// ---------------------------------------------------------------------------
// adder_cla_seq
//
// Multi-precision add/subtract sequencer. A single N-bit carry-lookahead adder
// (adder_cla) is time-shared over M slices of an N*M-bit operand pair. Slices
// are processed LSB first, one per clock. The carry is kept in a register
// between slices.
//
// Ports (adder_cla_seq):
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   command valid (op_a, op_b, sub)
//   in_ready   block can accept a command (IDLE only)
//   op_a       operand A, N*M bits
//   op_b       operand B, N*M bits
//   sub        0: A+B, 1: A-B (two's complement)
//   out_valid  result valid, held until out_ready (DONE only)
//   out_ready  downstream accepts the result
//   result     sum or difference, N*M bits
//   cout       carry out of the MSB (for sub: 1 means no borrow)
//   overflow   signed two's-complement overflow
//   busy       high while in RUN or DONE
//
// Ports (adder_cla):
//   a, b       N-bit addends
//   ci         carry in
//   s          N-bit sum
//   co         carry out
// ---------------------------------------------------------------------------

module adder_cla #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] s,
  output logic         co
);

  logic [N-1:0] gen_s;
  logic [N-1:0] prop_s;
  logic [N:0]   carry_s;

  assign gen_s  = a & b;
  assign prop_s = a ^ b;

  // Lookahead carries: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]ci, each
  // carry built directly from generate/propagate terms rather than rippled.
  always_comb begin
    logic acc_v;
    logic prod_v;
    carry_s    = {(N+1){1'b0}};
    carry_s[0] = ci;
    for (int i = 0; i < N; i++) begin
      acc_v  = gen_s[i];
      prod_v = prop_s[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc_v  = acc_v | (prod_v & gen_s[j]);
        prod_v = prod_v & prop_s[j];
      end
      carry_s[i+1] = acc_v | (prod_v & ci);
    end
  end

  assign s  = prop_s ^ carry_s[N-1:0];
  assign co = carry_s[N];

endmodule

module adder_cla_seq #(
  parameter int N = 4,
  parameter int M = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*M-1:0] op_a,
  input  logic [N*M-1:0] op_b,
  input  logic           sub,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*M-1:0] result,
  output logic           cout,
  output logic           overflow,
  output logic           busy
);

  localparam int W  = N * M;
  localparam int KW = (M > 1) ? $clog2(M) : 1;

  localparam logic [KW-1:0] K_ZERO = KW'(0);
  localparam logic [KW-1:0] K_ONE  = KW'(1);
  localparam logic [KW-1:0] K_LAST = KW'(M - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_r;
  logic [KW-1:0]   k_r;
  logic            carry_r;
  logic [W-1:0]    op_a_r;
  logic [W-1:0]    op_b_r;
  logic            sub_r;
  logic [W-1:0]    result_r;
  logic            cout_r;
  logic            overflow_r;
  logic            in_ready_r;
  logic            out_valid_r;
  logic            busy_r;

  logic [N-1:0]    a_slice_s;
  logic [N-1:0]    b_slice_s;
  logic [N-1:0]    sum_s;
  logic            co_s;
  logic            ovf_s;

  // Current slice operands; B is inverted for subtraction, the +1 comes from
  // the carry register being preloaded with sub.
  assign a_slice_s = op_a_r[k_r*N +: N];
  assign b_slice_s = op_b_r[k_r*N +: N] ^ {N{sub_r}};

  adder_cla #(.N(N)) u_adder (
    .a  (a_slice_s),
    .b  (b_slice_s),
    .ci (carry_r),
    .s  (sum_s),
    .co (co_s)
  );

  // Signed overflow is only meaningful on the top slice, where these MSBs are
  // the sign bits of the full-width operands.
  assign ovf_s = (a_slice_s[N-1] == b_slice_s[N-1]) & (sum_s[N-1] != a_slice_s[N-1]);

  // Control FSM with slice datapath; handshake flags are registered alongside
  // the state so no input reaches in_ready/out_valid combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      k_r         <= K_ZERO;
      carry_r     <= 1'b0;
      op_a_r      <= {W{1'b0}};
      op_b_r      <= {W{1'b0}};
      sub_r       <= 1'b0;
      result_r    <= {W{1'b0}};
      cout_r      <= 1'b0;
      overflow_r  <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            op_a_r     <= op_a;
            op_b_r     <= op_b;
            sub_r      <= sub;
            carry_r    <= sub;
            k_r        <= K_ZERO;
            state_r    <= RUN;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
          end
        end
        RUN: begin
          result_r[k_r*N +: N] <= sum_s;
          carry_r              <= co_s;
          if (k_r == K_LAST) begin
            cout_r      <= co_s;
            overflow_r  <= ovf_s;
            k_r         <= K_ZERO;
            state_r     <= DONE;
            out_valid_r <= 1'b1;
          end else begin
            k_r <= k_r + K_ONE;
          end
        end
        DONE: begin
          // Handoff returns to IDLE only; a new command is taken a cycle later.
          if (out_ready) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          k_r         <= K_ZERO;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          in_ready_r  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign result    = result_r;
  assign cout      = cout_r;
  assign overflow  = overflow_r;

endmodule
